// File: rtl/mul_seq_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// master drives the request side; slave is the multiplier itself.
interface mul_seq_if #(
  parameter int WIDTH = 16
);
  logic               ready;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   multiplicand;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               overflow;

  modport master (
    output ready, signed_mode, multiplier, multiplicand,
    input  busy, done, product, overflow
  );

  modport slave (
    input  ready, signed_mode, multiplier, multiplicand,
    output busy, done, product, overflow
  );
endinterface

// File: rtl/mul_seq.sv
// Shift-add sequential multiplier, signed/unsigned, WIDTH cycles per op.
// Define MUL_SEQ_EARLY_EN to finish as soon as the multiplier runs out of ones.
module mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  mul_seq_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] mplr_q;
  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic [PW-1:0]    product_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_nx;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    res;
  logic             ovf_nx;
  logic             last_edge;
  logic             mode_q;

  always_comb begin
    a_mag = bus.multiplier;
    b_mag = bus.multiplicand;
    if (bus.signed_mode && bus.multiplier[WIDTH-1])
      a_mag = -bus.multiplier;
    if (bus.signed_mode && bus.multiplicand[WIDTH-1])
      b_mag = -bus.multiplicand;
    // a zero operand always yields a positive result
    neg_nx = bus.signed_mode
           & (bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1])
           & (|a_mag) & (|b_mag);
  end

  always_comb begin
    acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
    res     = neg_q ? -acc_sum : acc_sum;
    if (mode_q)
      ovf_nx = !((res[PW-1:WIDTH-1] == '0) ||
                 (res[PW-1:WIDTH-1] == '1));
    else
      ovf_nx = |res[PW-1:WIDTH];
`ifdef MUL_SEQ_EARLY_EN
    last_edge = (cnt_q == CNT_LAST) ||
                (mplr_q[WIDTH-1:1] == '0);
`else
    last_edge = (cnt_q == CNT_LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.ready) state_nx = RUN;
      RUN:     if (last_edge) state_nx = LAST;
      LAST:    if (!bus.ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mplr_q    <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      mode_q    <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ready) begin
            mplr_q  <= a_mag;
            mcand_q <= {{WIDTH{1'b0}}, b_mag};
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= neg_nx;
            mode_q  <= bus.signed_mode;
          end
        end
        RUN: begin
          acc_q   <= acc_sum;
          mplr_q  <= mplr_q >> 1;
          mcand_q <= mcand_q << 1;
          cnt_q   <= cnt_q + CW'(1);
          if (last_edge) begin
            product_q <= res;
            ovf_q     <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == LAST);
  assign bus.product  = product_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq at WIDTH=16.
// Expected results come from a behavioural multiply model.
module tb_mul_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mul_seq_if #(.WIDTH(W)) bus ();

  mul_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    logic        o;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic int lat_of(logic [15:0] a, logic s);
    logic [15:0] mag;
    int l;
    mag = (s && a[15]) ? 16'(-a) : a;
`ifdef MUL_SEQ_EARLY_EN
    l = 1;
    for (int i = 0; i < 16; i++)
      if (mag[i]) l = i + 1;
`else
    l = 16;
    if (mag == 16'h0) l = 16;
`endif
    return l;
  endfunction

  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic s);
    exp_t m;
    longint sa, sbv, p;
    sa  = s ? longint'($signed(a)) : longint'(a);
    sbv = s ? longint'($signed(b)) : longint'(b);
    p   = sa * sbv;
    m.p = p[31:0];
    m.o = s ? ((p < -32768) || (p > 32767)) : (p > 65535);
    m.lat = lat_of(a, s);
    return m;
  endfunction

  task automatic start_op(logic [15:0] a, logic [15:0] b, logic s);
    @(negedge clk);
    bus.ready        = 1'b1;
    bus.multiplier   = a;
    bus.multiplicand = b;
    bus.signed_mode  = s;
    sb.push_back(model(a, b, s));
    @(posedge clk);
  endtask

  task automatic wait_done(input bit keep, output int lat,
                           output bit timeout, output bit saw_busy);
    lat = 0;
    timeout = 1'b1;
    @(negedge clk);
    saw_busy = bus.busy;
    if (!keep) begin
      bus.ready        = 1'b0;
      bus.multiplier   = 16'($urandom);
      bus.multiplicand = 16'($urandom);
      bus.signed_mode  = 1'($urandom);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.ready = 1'b0;
    bus.signed_mode = 1'b0;
    bus.multiplier = '0;
    bus.multiplicand = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests += 4;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done got %b want 0", bus.done);
    end
    if (bus.product !== 32'h0) begin
      n_fail++; $display("FAIL reset_product got %h want 0", bus.product);
    end
    if (bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf got %b want 0", bus.overflow);
    end
    reset = 1'b1;
  endtask

  task automatic test_signed_basic();
    exp_t e;
    int lat;
    bit to, bz;
    start_op(16'h0003, 16'hFFFB, 1'b1);
    wait_done(1'b0, lat, to, bz);
    e = sb.pop_front();
    n_tests += 6;
    if (bz !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy got %b want 1", bz);
    end
    if (to) begin
      n_fail++; $display("FAIL basic_timeout no done within 40 cycles");
    end
    if (lat != e.lat) begin
      n_fail++; $display("FAIL basic_latency got %0d want %0d", lat, e.lat);
    end
    if (bus.product !== e.p) begin
      n_fail++; $display("FAIL basic_product got %h want %h", bus.product, e.p);
    end
    if (bus.overflow !== e.o) begin
      n_fail++; $display("FAIL basic_ovf got %b want %b", bus.overflow, e.o);
    end
    @(negedge clk);
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_width got %b want 0", bus.done);
    end
  endtask

  task automatic test_corners();
    logic [15:0] ta[9] = '{16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF,
                           16'h0000, 16'h1234, 16'h0002, 16'h0000, 16'h7FFF};
    logic [15:0] tb_[9] = '{16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF,
                            16'hFFFB, 16'h0000, 16'h0007, 16'h0000, 16'h8000};
    logic ts[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t e;
    int lat;
    bit to, bz;
    for (int i = 0; i < 9; i++) begin
      start_op(ta[i], tb_[i], ts[i]);
      wait_done(1'b0, lat, to, bz);
      e = sb.pop_front();
      n_tests += 3;
      if (to || lat != e.lat) begin
        n_fail++;
        $display("FAIL corner%0d_latency got %0d want %0d", i, lat, e.lat);
      end
      if (bus.product !== e.p) begin
        n_fail++;
        $display("FAIL corner%0d_product got %h want %h", i, bus.product, e.p);
      end
      if (bus.overflow !== e.o) begin
        n_fail++;
        $display("FAIL corner%0d_ovf got %b want %b", i, bus.overflow, e.o);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int lat;
    bit to, bz;
    start_op(16'h0005, 16'h0006, 1'b0);
    wait_done(1'b1, lat, to, bz);
    e = sb.pop_front();
    n_tests += 2;
    if (to || bus.product !== e.p) begin
      n_fail++; $display("FAIL hold_product got %h want %h", bus.product, e.p);
    end
    if (bus.overflow !== e.o) begin
      n_fail++; $display("FAIL hold_ovf got %b want %b", bus.overflow, e.o);
    end
    bus.multiplier = 16'h00FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_done cyc%0d got done=%b busy=%b want 1/0",
                 i, bus.done, bus.busy);
      end
    end
    bus.ready = 1'b0;
    @(negedge clk);
    n_tests += 2;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release got done=%b busy=%b want 0/0",
               bus.done, bus.busy);
    end
    if (bus.product !== e.p) begin
      n_fail++; $display("FAIL hold_keep got %h want %h", bus.product, e.p);
    end
    start_op(16'h0011, 16'h0003, 1'b0);
    wait_done(1'b0, lat, to, bz);
    e = sb.pop_front();
    n_tests++;
    if (to || bus.product !== e.p) begin
      n_fail++; $display("FAIL hold_next got %h want %h", bus.product, e.p);
    end
  endtask

  task automatic test_midrun_reset();
    int seen;
    exp_t e;
    start_op(16'hFFFF, 16'h1234, 1'b0);
    e = sb.pop_front();
    @(negedge clk);
    bus.ready = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_tests += 3;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_state got busy=%b done=%b want 0/0",
               bus.busy, bus.done);
    end
    if (bus.product !== 32'h0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_product got %h/%b want 0/0 (discarded %h)",
               bus.product, bus.overflow, e.p);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_no_done got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    bit to, bz;
    logic [15:0] a, b;
    logic s;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      if (i == 0) a = 16'h0040;
      start_op(a, b, s);
      wait_done(1'b0, lat, to, bz);
      e = sb.pop_front();
      n_tests += 2;
      if (to || lat != e.lat) begin
        n_fail++;
        $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, e.lat);
      end
      if (bus.product !== e.p || bus.overflow !== e.o) begin
        n_fail++;
        $display("FAIL b2b%0d a=%h b=%h s=%b got %h/%b want %h/%b",
                 i, a, b, s, bus.product, bus.overflow, e.p, e.o);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_signed_basic();
    test_corners();
    test_hold();
    test_midrun_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving operand width in bits; legal range 4..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  one clock; reset is synchronous and active-low.
REQ-004 SHALL have port ready  input  1  start request, level-sensitive, may be held high indefinitely.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port multiplier  input  WIDTH  operand A.
REQ-007 SHALL have port multiplicand  input  WIDTH  operand B.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse; product valid.
REQ-010 SHALL have port product  output  2*WIDTH  registered result.
REQ-011 SHALL have port overflow  output  1  result does not fit in WIDTH bits under the captured mode.

Function
REQ-012 SHALL implement three states: IDLE, RUN, LAST; done = (state == LAST), busy = (state == RUN).
REQ-013 IDLE: on an edge with ready=1, SHALL capture operands and signed_mode and go to RUN; ready=0 stays IDLE.
REQ-014 Capture SHALL store operand magnitudes (negate when signed_mode=1 and MSB=1) and the result sign (MSB XOR MSB in signed mode, 0 in unsigned).
REQ-015 Most-negative signed operand (e.g. 0x8000 at WIDTH=16) SHALL yield magnitude 2^(WIDTH-1) without error.
REQ-016 RUN: each edge SHALL add the shifted multiplicand magnitude to a 2*WIDTH accumulator when multiplier LSB=1, then shift the multiplier right and the multiplicand left by one.
REQ-017 RUN SHALL last exactly WIDTH edges; on the WIDTH-th, the final accumulator (negated if result sign=1) SHALL be loaded into product and state SHALL go to LAST.
REQ-018 done SHALL be high in the cycle following the WIDTH-th edge after the capture edge (16 cycles at WIDTH=16).
REQ-019 ready changes during RUN SHALL be ignored; an operation SHALL never abort except by reset.
REQ-020 LAST: ready=1 SHALL hold LAST (done stays high) until ready=0, then IDLE; a new operation SHALL require ready low then high.
REQ-021 Operand inputs SHALL be ignored outside the IDLE capture edge.
REQ-022 product SHALL hold its value from LAST until the next capture edge; it SHALL NOT clear in IDLE.
REQ-023 overflow SHALL derive from product and the captured mode: signed -> product outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]; unsigned -> product >= 2^WIDTH.
REQ-024 Zero operand SHALL give product 0, positive sign, overflow 0.

Reset
REQ-025 reset=0 at an edge SHALL force IDLE and clear product, accumulator, operand copies, sign, count; done=0, busy=0, overflow=0 next cycle.
REQ-026 Reset mid-RUN or in LAST SHALL discard the operation without emitting done.
REQ-027 After reset releases, the first edge with ready=1 SHALL start a new operation normally.

Configuration
REQ-028 Macro MUL_SEQ_EARLY_EN defined: RUN SHALL go to LAST on the edge where the shifted multiplier magnitude becomes zero or the WIDTH-th edge, whichever comes first; latency = max(1, bit index of the multiplier magnitude's highest set bit + 1) edges.
REQ-029 Macro MUL_SEQ_EARLY_EN undefined: latency SHALL be fixed at WIDTH edges; results SHALL be identical in both builds.

Verification
REQ-030 WIDTH=16, signed, 3 x -5 (0xFFFB) -> product 0xFFFFFFF1, overflow 0, done exactly 16 cycles after capture, one cycle wide if ready low.
REQ-031 Signed 0x8000 x 0x8000 -> product 0x40000000, overflow 1; signed 0x8000 x 0x0001 -> 0xFFFF8000, overflow 0.
REQ-032 0xFFFF x 0xFFFF unsigned -> 0xFFFE0001, overflow 1; same operands signed -> 0x00000001, overflow 0.
REQ-033 ready held high across completion -> done stays high, no second operation; drop ready one cycle then raise -> new operation starts, product held meanwhile.
REQ-034 reset=0 asserted on 8th RUN cycle -> next cycle IDLE, product 0, busy 0, no done pulse.
REQ-035 MUL_SEQ_EARLY_EN defined: multiplier 0x0002 x 0x0007 -> product 0x0000000E, done after 2 RUN edges; multiplier 0 -> done after 1 RUN edge, product 0.
